// File: rtl/usb3_ep_pkg.sv
// Shared definitions for the USB 3.0 endpoint buffer blocks.
// Endpoint transfer-type encodings and small arithmetic helpers.
package usb3_ep_pkg;

  typedef enum logic [1:0] {
    EP_MODE_CONTROL   = 2'd0,
    EP_MODE_ISOCH     = 2'd1,
    EP_MODE_BULK      = 2'd2,
    EP_MODE_INTERRUPT = 2'd3
  } ep_mode_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/usb3_ep_ring_ram.sv
// Simple dual-port packet RAM: one write port, one read port with a registered,
// synchronously cleared output.
module usb3_ep_ring_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              local_clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge local_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Storage itself is never cleared; only the read register is.
  always_ff @(posedge local_clk) begin
    if (reset) q <= '0;
    else       q <= mem[raddr];
  end

endmodule

// File: rtl/usb3_ep_ring.sv
// Ring of NUM_BUF endpoint packet buffers between the link layer (producer)
// and the application (consumer), with per-mode full-ring policy.
module usb3_ep_ring
  import usb3_ep_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int BUF_WORDS = 256,
  parameter int NUM_BUF   = 4,
  parameter int LEN_W     = 11,
  localparam int ADDR_W   = $clog2(BUF_WORDS),
  localparam int PTR_W    = $clog2(NUM_BUF)
) (
  input  logic              local_clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] buf_in_addr,
  input  logic [DATA_W-1:0] buf_in_data,
  input  logic              buf_in_wren,
  output logic              buf_in_ready,
  input  logic              buf_in_commit,
  input  logic [LEN_W-1:0]  buf_in_commit_len,
  output logic              buf_in_commit_ack,
  output logic              buf_in_commit_nak,
  input  logic [ADDR_W-1:0] buf_out_addr,
  output logic [DATA_W-1:0] buf_out_q,
  output logic [LEN_W-1:0]  buf_out_len,
  output logic              buf_out_hasdata,
  input  logic              buf_out_arm,
  output logic              buf_out_arm_ack,
  input  logic [1:0]        mode,
  input  logic              flush,
  output logic [PTR_W:0]    level,
  output logic [7:0]        overflow_cnt
);

  localparam logic [LEN_W-1:0] MAXLEN   = LEN_W'(BUF_WORDS * DATA_W / 8);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(NUM_BUF);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [LEN_W-1:0] len_q [NUM_BUF];

  logic             full;
  logic             empty;
  logic             is_isoch;
  logic             arm_ok;
  logic             commit_acc;
  logic             commit_ovw;
  logic             commit_rej;
  logic [LEN_W-1:0] len_clamped;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign is_isoch = (mode == EP_MODE_ISOCH);

  // Requests are judged against the registered count; flush swallows both.
  assign arm_ok     = buf_out_arm & ~empty & ~flush;
  assign commit_acc = buf_in_commit & ~flush & (~full | arm_ok);
  assign commit_ovw = buf_in_commit & ~flush & full & ~arm_ok & is_isoch;
  assign commit_rej = buf_in_commit & ~flush & full & ~arm_ok & ~is_isoch;

  assign len_clamped = (buf_in_commit_len > MAXLEN) ? MAXLEN : buf_in_commit_len;

  assign buf_in_ready    = ~full | is_isoch;
  assign buf_out_hasdata = ~empty;
  assign buf_out_len     = len_q[rd_ptr];
  assign level           = count;

  always_ff @(posedge local_clk) begin
    if (reset) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      overflow_cnt      <= '0;
      buf_in_commit_ack <= 1'b0;
      buf_in_commit_nak <= 1'b0;
      buf_out_arm_ack   <= 1'b0;
      for (int i = 0; i < NUM_BUF; i++) len_q[i] <= '0;
    end else begin
      buf_in_commit_ack <= commit_acc | commit_ovw;
      buf_in_commit_nak <= commit_rej;
      buf_out_arm_ack   <= arm_ok;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (commit_acc | commit_ovw) begin
          len_q[wr_ptr] <= len_clamped;
          wr_ptr        <= wr_ptr + 1'b1;
        end
        // An isoch overwrite retires the oldest buffer, so rd_ptr follows wr_ptr.
        if (arm_ok | commit_ovw) rd_ptr <= rd_ptr + 1'b1;
        if (commit_acc & ~arm_ok)      count <= count + 1'b1;
        else if (arm_ok & ~commit_acc) count <= count - 1'b1;
        if (commit_ovw) overflow_cnt <= sat_inc8(overflow_cnt);
      end
    end
  end

  usb3_ep_ring_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (NUM_BUF * BUF_WORDS)
  ) u_ram (
    .local_clk (local_clk),
    .reset     (reset),
    .we        (buf_in_wren & buf_in_ready),
    .waddr     ({wr_ptr, buf_in_addr}),
    .wdata     (buf_in_data),
    .raddr     ({rd_ptr, buf_out_addr}),
    .q         (buf_out_q)
  );

endmodule

// File: tb/tb_usb3_ep_ring.sv
// Self-checking bench for usb3_ep_ring: directed vector table, hand sequences
// and a randomized run against a packet-queue reference model.
module tb_usb3_ep_ring;

  logic        local_clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  buf_in_addr = '0;
  logic [31:0] buf_in_data = '0;
  logic        buf_in_wren = 1'b0;
  logic        buf_in_ready;
  logic        buf_in_commit = 1'b0;
  logic [10:0] buf_in_commit_len = '0;
  logic        buf_in_commit_ack;
  logic        buf_in_commit_nak;
  logic [7:0]  buf_out_addr = '0;
  logic [31:0] buf_out_q;
  logic [10:0] buf_out_len;
  logic        buf_out_hasdata;
  logic        buf_out_arm = 1'b0;
  logic        buf_out_arm_ack;
  logic [1:0]  mode = 2'd2;
  logic        flush = 1'b0;
  logic [2:0]  level;
  logic [7:0]  overflow_cnt;

  int checks = 0;
  int errors = 0;

  usb3_ep_ring dut (
    .local_clk         (local_clk),
    .reset             (reset),
    .buf_in_addr       (buf_in_addr),
    .buf_in_data       (buf_in_data),
    .buf_in_wren       (buf_in_wren),
    .buf_in_ready      (buf_in_ready),
    .buf_in_commit     (buf_in_commit),
    .buf_in_commit_len (buf_in_commit_len),
    .buf_in_commit_ack (buf_in_commit_ack),
    .buf_in_commit_nak (buf_in_commit_nak),
    .buf_out_addr      (buf_out_addr),
    .buf_out_q         (buf_out_q),
    .buf_out_len       (buf_out_len),
    .buf_out_hasdata   (buf_out_hasdata),
    .buf_out_arm       (buf_out_arm),
    .buf_out_arm_ack   (buf_out_arm_ack),
    .mode              (mode),
    .flush             (flush),
    .level             (level),
    .overflow_cnt      (overflow_cnt)
  );

  always #5 local_clk = ~local_clk;

  localparam logic [1:0] M_CTRL = 2'd0;
  localparam logic [1:0] M_ISO  = 2'd1;
  localparam logic [1:0] M_BULK = 2'd2;
  localparam logic [1:0] M_INT  = 2'd3;

  typedef struct {
    logic        commit;
    logic [10:0] len;
    logic        arm;
    logic        flsh;
    logic [1:0]  md;
    logic        e_ack;
    logic        e_nak;
    logic        e_arm;
    logic [2:0]  e_level;
    logic        e_ready;
    logic        chk_len;
    logic [10:0] e_len;
    logic [7:0]  e_ovf;
  } vec_t;

  typedef struct {
    int          len;
    logic [31:0] tag;
  } pkt_t;

  vec_t vecs[17];
  pkt_t mq[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; outputs are stable at the next falling edge.
  task automatic applyStimulus(input logic c, input logic [10:0] l, input logic a, input logic f,
                               input logic w, input logic [7:0] wa, input logic [31:0] wd);
    buf_in_commit     = c;
    buf_in_commit_len = l;
    buf_out_arm       = a;
    flush             = f;
    buf_in_wren       = w;
    buf_in_addr       = wa;
    buf_in_data       = wd;
    @(posedge local_clk);
    @(negedge local_clk);
    buf_in_commit = 1'b0;
    buf_out_arm   = 1'b0;
    flush         = 1'b0;
    buf_in_wren   = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(posedge local_clk);
    @(posedge local_clk);
    @(negedge local_clk);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'h5A5A0000 + 32'(i) * 32'h00000101;
  endfunction

  initial begin
    int ack_seen;
    logic [2:0] lvl_prev;

    // Directed vectors, starting from an empty ring with wr/rd aligned.
    vecs[0]  = '{1'b1, 11'd100,  1'b0, 1'b0, M_BULK, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 11'd100,  8'd0};
    vecs[1]  = '{1'b1, 11'd200,  1'b0, 1'b0, M_BULK, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 11'd100,  8'd0};
    vecs[2]  = '{1'b1, 11'd300,  1'b1, 1'b0, M_BULK, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 11'd200,  8'd0};
    vecs[3]  = '{1'b1, 11'd400,  1'b0, 1'b0, M_BULK, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 11'd200,  8'd0};
    vecs[4]  = '{1'b1, 11'd500,  1'b0, 1'b0, M_BULK, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 11'd200,  8'd0};
    vecs[5]  = '{1'b1, 11'd600,  1'b0, 1'b0, M_BULK, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 1'b1, 11'd200,  8'd0};
    vecs[6]  = '{1'b1, 11'd700,  1'b1, 1'b0, M_BULK, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 11'd300,  8'd0};
    vecs[7]  = '{1'b0, 11'd0,    1'b1, 1'b0, M_BULK, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 11'd400,  8'd0};
    vecs[8]  = '{1'b1, 11'd50,   1'b0, 1'b1, M_BULK, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 11'd0,    8'd0};
    vecs[9]  = '{1'b0, 11'd0,    1'b1, 1'b0, M_BULK, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 11'd0,    8'd0};
    vecs[10] = '{1'b1, 11'd2000, 1'b1, 1'b0, M_BULK, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 11'd1024, 8'd0};
    vecs[11] = '{1'b0, 11'd0,    1'b1, 1'b0, M_ISO,  1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 11'd0,    8'd0};
    vecs[12] = '{1'b1, 11'd10,   1'b0, 1'b0, M_ISO,  1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 11'd10,   8'd0};
    vecs[13] = '{1'b1, 11'd20,   1'b0, 1'b0, M_ISO,  1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 11'd10,   8'd0};
    vecs[14] = '{1'b1, 11'd30,   1'b0, 1'b0, M_ISO,  1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 11'd10,   8'd0};
    vecs[15] = '{1'b1, 11'd40,   1'b0, 1'b0, M_ISO,  1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 11'd10,   8'd0};
    vecs[16] = '{1'b1, 11'd100,  1'b0, 1'b0, M_ISO,  1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 11'd20,   8'd1};

    mode = M_BULK;
    doReset();

    checkOutput("reset_ready",   32'(buf_in_ready),      32'd1);
    checkOutput("reset_hasdata", 32'(buf_out_hasdata),   32'd0);
    checkOutput("reset_level",   32'(level),             32'd0);
    checkOutput("reset_len",     32'(buf_out_len),       32'd0);
    checkOutput("reset_ack",     32'(buf_in_commit_ack), 32'd0);
    checkOutput("reset_nak",     32'(buf_in_commit_nak), 32'd0);
    checkOutput("reset_arm_ack", 32'(buf_out_arm_ack),   32'd0);
    checkOutput("reset_q",       buf_out_q,              32'd0);
    checkOutput("reset_ovf",     32'(overflow_cnt),      32'd0);

    // Full buffer write, commit and readback with one-cycle read latency.
    for (int i = 0; i < 256; i++) applyStimulus(1'b0, 11'd0, 1'b0, 1'b0, 1'b1, 8'(i), pat(i));
    applyStimulus(1'b1, 11'd1024, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
    checkOutput("fill_ack",     32'(buf_in_commit_ack), 32'd1);
    checkOutput("fill_hasdata", 32'(buf_out_hasdata),   32'd1);
    checkOutput("fill_level",   32'(level),             32'd1);
    checkOutput("fill_len",     32'(buf_out_len),       32'd1024);
    for (int i = 0; i < 256; i++) begin
      buf_out_addr = 8'(i);
      @(negedge local_clk);
      if (i == 0) checkOutput("fill_ack_one_cycle", 32'(buf_in_commit_ack), 32'd0);
      checkOutput("fill_readback", buf_out_q, pat(i));
    end
    applyStimulus(1'b0, 11'd0, 1'b1, 1'b0, 1'b0, 8'd0, 32'd0);
    checkOutput("fill_arm_ack", 32'(buf_out_arm_ack), 32'd1);
    checkOutput("fill_arm_lvl", 32'(level),           32'd0);

    // Table of single-cycle events.
    foreach (vecs[k]) begin
      mode = vecs[k].md;
      applyStimulus(vecs[k].commit, vecs[k].len, vecs[k].arm, vecs[k].flsh, 1'b0, 8'd0, 32'd0);
      checkOutput($sformatf("vec%0d_ack", k),     32'(buf_in_commit_ack), 32'(vecs[k].e_ack));
      checkOutput($sformatf("vec%0d_nak", k),     32'(buf_in_commit_nak), 32'(vecs[k].e_nak));
      checkOutput($sformatf("vec%0d_arm_ack", k), 32'(buf_out_arm_ack),   32'(vecs[k].e_arm));
      checkOutput($sformatf("vec%0d_level", k),   32'(level),             32'(vecs[k].e_level));
      checkOutput($sformatf("vec%0d_ready", k),   32'(buf_in_ready),      32'(vecs[k].e_ready));
      checkOutput($sformatf("vec%0d_hasdata", k), 32'(buf_out_hasdata),   32'(vecs[k].e_level != 3'd0));
      checkOutput($sformatf("vec%0d_ovf", k),     32'(overflow_cnt),      32'(vecs[k].e_ovf));
      if (vecs[k].chk_len) checkOutput($sformatf("vec%0d_len", k), 32'(buf_out_len), 32'(vecs[k].e_len));
    end

    // Isoch overflow counter saturation with back-to-back commits at full.
    ack_seen = 0;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 11'd7, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
      if (buf_in_commit_ack === 1'b1) ack_seen++;
    end
    checkOutput("sat_acks",  32'(ack_seen),     32'd300);
    checkOutput("sat_ovf",   32'(overflow_cnt), 32'd255);
    checkOutput("sat_level", 32'(level),        32'd4);
    checkOutput("sat_len",   32'(buf_out_len),  32'd7);

    // Reset while the ring is full.
    doReset();
    checkOutput("midrst_level",   32'(level),           32'd0);
    checkOutput("midrst_hasdata", 32'(buf_out_hasdata), 32'd0);
    checkOutput("midrst_ovf",     32'(overflow_cnt),    32'd0);
    checkOutput("midrst_len",     32'(buf_out_len),     32'd0);
    checkOutput("midrst_ready",   32'(buf_in_ready),    32'd1);

    // Wrap-around: ten packets through the ring, each with its own length and data.
    mode = M_BULK;
    @(negedge local_clk);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b1, 11'(i), 1'b0, 1'b0, 1'b1, 8'd5, 32'hD00D0000 + 32'(i));
      checkOutput($sformatf("wrap%0d_ack", i), 32'(buf_in_commit_ack), 32'd1);
      checkOutput($sformatf("wrap%0d_len", i), 32'(buf_out_len),       32'(i));
      buf_out_addr = 8'd5;
      @(negedge local_clk);
      checkOutput($sformatf("wrap%0d_q", i), buf_out_q, 32'hD00D0000 + 32'(i));
      applyStimulus(1'b0, 11'd0, 1'b1, 1'b0, 1'b0, 8'd0, 32'd0);
      checkOutput($sformatf("wrap%0d_arm_ack", i), 32'(buf_out_arm_ack), 32'd1);
      checkOutput($sformatf("wrap%0d_level", i),   32'(level),           32'd0);
    end

    // A write while the bulk ring is full must not corrupt the oldest buffer.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 11'd8, 1'b0, 1'b0, 1'b1, 8'd3, 32'hCAFE0000 + 32'(i));
    applyStimulus(1'b0, 11'd0, 1'b0, 1'b0, 1'b1, 8'd3, 32'hDEADBEEF);
    buf_out_addr = 8'd3;
    @(negedge local_clk);
    checkOutput("dropwr_q", buf_out_q, 32'hCAFE0000);
    applyStimulus(1'b0, 11'd0, 1'b0, 1'b1, 1'b0, 8'd0, 32'd0);

    // Randomized run against a queue-of-packets model.
    doReset();
    mq.delete();
    buf_out_addr = 8'd0;
    begin
      int ovf_m;
      logic [1:0] modes[4];
      ovf_m = 0;
      modes[0] = M_CTRL; modes[1] = M_ISO; modes[2] = M_BULK; modes[3] = M_INT;
      for (int ph = 0; ph < 4; ph++) begin
        mode = modes[ph];
        applyStimulus(1'b0, 11'd0, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
        for (int s = 0; s < 150; s++) begin
          logic c, a, f, wr, e_ack, e_nak, e_arm, pre_ne, full_m, arm_ok, acc, ovw;
          logic [10:0] l;
          logic [31:0] tag, pre_head, newtag;
          full_m   = (mq.size() == 4);
          wr       = !full_m;
          tag      = $urandom;
          c        = ($urandom_range(0, 1) == 1);
          a        = ($urandom_range(0, 99) < 35);
          f        = ($urandom_range(0, 99) < 3);
          l        = 11'($urandom_range(0, 2047));
          pre_ne   = (mq.size() > 0);
          pre_head = pre_ne ? mq[0].tag : 32'd0;
          e_ack = 1'b0; e_nak = 1'b0; e_arm = 1'b0;
          if (f) begin
            mq.delete();
          end else begin
            arm_ok = a && (mq.size() > 0);
            acc    = c && ((mq.size() < 4) || arm_ok);
            ovw    = c && !acc && (mode == M_ISO);
            e_nak  = c && !acc && !ovw;
            e_ack  = acc || ovw;
            e_arm  = arm_ok;
            newtag = full_m ? pre_head : tag;
            if (arm_ok) void'(mq.pop_front());
            if (ovw) begin
              void'(mq.pop_front());
              if (ovf_m < 255) ovf_m++;
            end
            if (acc || ovw) mq.push_back('{(int'(l) > 1024) ? 1024 : int'(l), newtag});
          end
          applyStimulus(c, l, a, f, wr, 8'd0, tag);
          checkOutput("rnd_ack",     32'(buf_in_commit_ack), 32'(e_ack));
          checkOutput("rnd_nak",     32'(buf_in_commit_nak), 32'(e_nak));
          checkOutput("rnd_arm_ack", 32'(buf_out_arm_ack),   32'(e_arm));
          checkOutput("rnd_level",   32'(level),             32'(mq.size()));
          checkOutput("rnd_hasdata", 32'(buf_out_hasdata),   32'(mq.size() > 0));
          checkOutput("rnd_ready",   32'(buf_in_ready),      32'((mq.size() < 4) || (mode == M_ISO)));
          checkOutput("rnd_ovf",     32'(overflow_cnt),      32'(ovf_m));
          if (mq.size() > 0) checkOutput("rnd_len", 32'(buf_out_len), 32'(mq[0].len));
          if (pre_ne) checkOutput("rnd_q", buf_out_q, pre_head);
          lvl_prev = level;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb3_ep_ring.md
# usb3_ep_ring

Parametrised multi-buffer endpoint store: generalises the two-buffer ping-pong endpoint to a ring of NUM_BUF packet buffers with configurable word width and buffer depth. The producer fills the buffer at the write pointer and commits it with a length; the consumer reads the oldest committed buffer and arms it free. It sits between the protocol/link layer and the application data path of a USB 3.0 endpoint. It adds per-mode full-ring policy (back-pressure for bulk/control/interrupt, overwrite-oldest for isochronous), a NAK on a rejected commit, flush, an occupancy level and an overflow counter.

## Interface
- DATA_W, 32, RAM word width in bits (multiple of 8)
- BUF_WORDS, 256, words per buffer (power of 2); ADDR_W = clog2(BUF_WORDS)
- NUM_BUF, 4, number of buffers (power of 2, >= 2); PTR_W = clog2(NUM_BUF)
- LEN_W, 11, byte-length width; must hold BUF_WORDS*DATA_W/8 (MAXLEN)

Ports:
- local_clk  in  1  single clock for all logic and RAM
- reset  in  1  synchronous, active-high
- buf_in_addr  in  ADDR_W  word address within the current write buffer
- buf_in_data  in  DATA_W  write data
- buf_in_wren  in  1  write strobe
- buf_in_ready  out  1  current write buffer may be written
- buf_in_commit  in  1  single-cycle pulse: current write buffer is complete
- buf_in_commit_len  in  LEN_W  byte count, sampled with buf_in_commit
- buf_in_commit_ack  out  1  one-cycle pulse: commit accepted
- buf_in_commit_nak  out  1  one-cycle pulse: commit rejected (ring full)
- buf_out_addr  in  ADDR_W  word address within the oldest committed buffer
- buf_out_q  out  DATA_W  read data
- buf_out_len  out  LEN_W  byte length of the oldest committed buffer
- buf_out_hasdata  out  1  at least one committed buffer is pending
- buf_out_arm  in  1  single-cycle pulse: release the oldest buffer
- buf_out_arm_ack  out  1  one-cycle pulse: release accepted
- mode  in  2  EP_MODE_CONTROL=0, ISOCH=1, BULK=2, INTERRUPT=3; change only while no commit pending
- flush  in  1  single-cycle pulse: discard all buffers
- level  out  PTR_W+1  number of committed buffers (0..NUM_BUF)
- overflow_cnt  out  8  isoch overwrites, saturating at 255

## Operation
- State: wr_ptr, rd_ptr (PTR_W, wrap modulo NUM_BUF), count (PTR_W+1), len[NUM_BUF] array, overflow_cnt.
- RAM address: write {wr_ptr, buf_in_addr}, read {rd_ptr, buf_out_addr}; total depth NUM_BUF*BUF_WORDS.
- full = (count == NUM_BUF); empty = (count == 0); level = count.
- buf_in_ready = ~full | (mode == ISOCH). RAM writes require buf_in_wren & buf_in_ready. Writes while not ready are dropped.
- buf_out_hasdata = ~empty; buf_out_len = len[rd_ptr].
- Commit accepted when ~full, or when full with a simultaneous accepted arm:
  - len[wr_ptr] <= min(buf_in_commit_len, MAXLEN).
  - wr_ptr increments; count increments.
- Commit when full with no arm:
  - Non-isoch: no state change; nak pulse.
  - Isoch: overwrite-oldest. The buffer just written is the oldest (wr_ptr == rd_ptr). len is stored, both pointers increment, count is unchanged, overflow_cnt increments (saturating), ack pulse. The consumer must not read during an isoch overflow; its data is undefined.
- Arm accepted when ~empty: rd_ptr increments, count decrements, arm_ack pulse. Arm when empty is ignored, with no ack.
- Commit and arm in the same cycle: both are evaluated against the registered count. Result: count unchanged, both acks. When empty, the arm is ignored and the commit is accepted.
- Flush takes priority over commit and arm in the same cycle. Both are dropped with no ack or nak. Pointers and count go to 0. len and overflow_cnt are kept.
- mode is sampled in the commit cycle.

## Timing
- Reset values:
  - wr_ptr, rd_ptr, count, overflow_cnt, all len = 0.
  - buf_in_ready = 1; buf_out_hasdata = 0; level = 0; buf_out_len = 0.
  - commit_ack, commit_nak, arm_ack = 0; buf_out_q = 0.
- Reset mid-operation discards all state the same way; RAM contents are not cleared.
- ack/nak/arm_ack are registered: high exactly one cycle, the cycle after the request pulse.
- Pointer, count, level, ready, hasdata and len updates are visible in that same cycle.
- Back-to-back commits (every cycle) are accepted up to full.
- Read latency is 1 cycle: buf_out_q is valid the cycle after buf_out_addr, for the rd_ptr current at the address cycle.
- Write-to-read of the same word after commit: the committed data is readable from the cycle after ack.

## Structure
- Shared package usb3_ep_pkg: EP_MODE_* constants, and a clog2 helper if the toolchain lacks $clog2.
- Sub-module usb3_ep_ring_ram: simple dual-port RAM, one clock, registered read output with synchronous reset, parameters DATA_W and depth.
- Ring control (pointers, count, len array, policy, pulses) lives in the top module.

## Test plan
- Reset, then write 256 words to buffer 0 and commit len=1024 -> ack 1 cycle later; hasdata=1; level=1; buf_out_len=1024; readback matches with 1-cycle latency.
- BULK: 4 commits -> level=4, ready=0. 5th commit -> nak, no ack, level stays 4. Then arm -> arm_ack, level=3, ready=1.
- ISOCH: fill 4 buffers, then commit len=100 -> ack, level=4, overflow_cnt=1, and buf_out_len becomes the 2nd-committed length. 300 overflows -> overflow_cnt=255.
- Simultaneous events:
  - commit+arm with level=2 -> both acks, level=2.
  - commit+arm at full in BULK -> both acks, level=4.
  - commit+arm when empty -> ack only, level=1.
- Wrap-around: 10 commit/arm cycles with distinct lengths 1..10 -> buf_out_len sequence 1..10; pointers wrap; data is not aliased.
- Flush with level=3 plus a concurrent commit -> no ack, level=0, hasdata=0. Commit len=2000 -> buf_out_len=1024 (saturated).
